// File: rtl/memory_access_pkg.sv
// Shared types and helpers for the V850 MEM stage: opcode enum, FSM states,
// byte-enable / store-lane / alignment helpers.
package memory_access_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_LD_B  = 4'd1,
        OP_LD_BU = 4'd2,
        OP_LD_H  = 4'd3,
        OP_LD_HU = 4'd4,
        OP_LD_W  = 4'd5,
        OP_ST_B  = 4'd6,
        OP_ST_H  = 4'd7,
        OP_ST_W  = 4'd8
    } mem_op_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    function automatic logic is_load(input mem_op_t op);
        return (op == OP_LD_B) || (op == OP_LD_BU) || (op == OP_LD_H) ||
               (op == OP_LD_HU) || (op == OP_LD_W);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == OP_ST_B) || (op == OP_ST_H) || (op == OP_ST_W);
    endfunction

    function automatic logic is_byte(input mem_op_t op);
        return (op == OP_LD_B) || (op == OP_LD_BU) || (op == OP_ST_B);
    endfunction

    function automatic logic is_half(input mem_op_t op);
        return (op == OP_LD_H) || (op == OP_LD_HU) || (op == OP_ST_H);
    endfunction

    // Halfwords ignore a[0] and words ignore a[1:0] unless the trap is enabled.
    function automatic logic [3:0] byte_enable(input mem_op_t op, input logic [1:0] a);
        if (is_byte(op))
            return 4'b0001 << a;
        else if (is_half(op))
            return 4'b0011 << {a[1], 1'b0};
        else
            return 4'hF;
    endfunction

    function automatic logic [DATA_W-1:0] store_lanes(input mem_op_t op,
                                                     input logic [DATA_W-1:0] d);
        if (is_byte(op))
            return {4{d[7:0]}};
        else if (is_half(op))
            return {2{d[15:0]}};
        else
            return d;
    endfunction

    function automatic logic misaligned(input mem_op_t op, input logic [1:0] a);
        if (is_half(op))
            return a[0];
        else if (op == OP_LD_W || op == OP_ST_W)
            return |a;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Combinational load-data alignment: picks the addressed byte/halfword lane
// out of the bus word and sign- or zero-extends it according to the opcode.
module memory_access_load_align
    import memory_access_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] value
);

    logic [7:0]  lane_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_bytes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = lane_bytes[addr];
    assign sel_half = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        value = rdata;
        case (mem_op_t'(op))
            OP_LD_B:  value = {{24{sel_byte[7]}}, sel_byte};
            OP_LD_BU: value = {24'h0, sel_byte};
            OP_LD_H:  value = {{16{sel_half[15]}}, sel_half};
            OP_LD_HU: value = {16'h0, sel_half};
            default:  value = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// V850 MEM stage: issues the data-memory req/ack transaction, aligns load data
// and registers the writeback packet. Optional macro: MEM_MISALIGN_TRAP_EN.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] memory_address_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] result_i,
    input  logic [31:0] result2_i,
    input  logic [4:0]  destination_i,
    input  logic [4:0]  destination2_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        wb_valid_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] wb_data2_o,
    output logic [4:0]  wb_dest_o,
    output logic [4:0]  wb_dest2_o,
    output logic        bus_err_o
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t             state_reg;
    mem_op_t            op_reg;
    logic [1:0]         addr_lo_reg;
    logic [REG_W-1:0]   dest_reg;
    logic [CNT_W-1:0]   timeout_cnt_reg;
    logic [DATA_W-1:0]  load_value;
    mem_op_t            in_op;
    logic               in_is_mem;

    assign in_op     = mem_op_t'(op_i);
    assign in_is_mem = is_load(in_op) || is_store(in_op);
    assign stall_o   = (state_reg == ST_ACCESS);

    memory_access_load_align u_load_align (
        .rdata (mem_rdata_i),
        .addr  (addr_lo_reg),
        .op    (op_reg),
        .value (load_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            op_reg          <= OP_NONE;
            addr_lo_reg     <= 2'b00;
            dest_reg        <= '0;
            timeout_cnt_reg <= '0;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= '0;
            mem_be_o        <= '0;
            mem_wdata_o     <= '0;
            wb_valid_o      <= 1'b0;
            wb_data_o       <= '0;
            wb_data2_o      <= '0;
            wb_dest_o       <= '0;
            wb_dest2_o      <= '0;
            bus_err_o       <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (!in_is_mem) begin
                            wb_valid_o <= 1'b1;
                            wb_data_o  <= result_i;
                            wb_data2_o <= result2_i;
                            wb_dest_o  <= destination_i;
                            wb_dest2_o <= destination2_i;
                        end else begin
`ifdef MEM_MISALIGN_TRAP_EN
                            if (misaligned(in_op, memory_address_i[1:0])) begin
                                bus_err_o <= 1'b1;
                            end else
`endif
                            begin
                                state_reg       <= ST_ACCESS;
                                mem_req_o       <= 1'b1;
                                mem_we_o        <= is_store(in_op);
                                mem_addr_o      <= {memory_address_i[31:2], 2'b00};
                                mem_be_o        <= byte_enable(in_op, memory_address_i[1:0]);
                                mem_wdata_o     <= store_lanes(in_op, store_data_i);
                                op_reg          <= in_op;
                                addr_lo_reg     <= memory_address_i[1:0];
                                dest_reg        <= destination_i;
                                timeout_cnt_reg <= '0;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ack on the final timeout cycle still completes normally.
                    if (mem_ack_i) begin
                        state_reg       <= ST_IDLE;
                        mem_req_o       <= 1'b0;
                        timeout_cnt_reg <= '0;
                        wb_valid_o      <= 1'b1;
                        wb_data2_o      <= '0;
                        wb_dest2_o      <= '0;
                        if (is_load(op_reg)) begin
                            wb_data_o <= load_value;
                            wb_dest_o <= dest_reg;
                        end else begin
                            wb_data_o <= '0;
                            wb_dest_o <= '0;
                        end
                    end else if (timeout_cnt_reg == CNT_LAST) begin
                        state_reg       <= ST_IDLE;
                        mem_req_o       <= 1'b0;
                        timeout_cnt_reg <= '0;
                        bus_err_o       <= 1'b1;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: passthrough, loads, stores, timeout,
// async reset mid-access and misalignment handling.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [3:0]  op_i;
    logic [31:0] memory_address_i;
    logic [31:0] store_data_i;
    logic [31:0] result_i;
    logic [31:0] result2_i;
    logic [4:0]  destination_i;
    logic [4:0]  destination2_i;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data2_o;
    logic [4:0]  wb_dest_o;
    logic [4:0]  wb_dest2_o;
    logic        bus_err_o;

    int total_cnt = 0;
    int pass_cnt  = 0;

    localparam logic [3:0] NONE = 4'd0, LD_B = 4'd1, LD_BU = 4'd2, LD_H = 4'd3,
                           LD_HU = 4'd4, LD_W = 4'd5, ST_B = 4'd6, ST_H = 4'd7,
                           ST_W = 4'd8;

    memory_access #(.ACK_TIMEOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_i          (valid_i),
        .op_i             (op_i),
        .memory_address_i (memory_address_i),
        .store_data_i     (store_data_i),
        .result_i         (result_i),
        .result2_i        (result2_i),
        .destination_i    (destination_i),
        .destination2_i   (destination2_i),
        .stall_o          (stall_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_be_o         (mem_be_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_rdata_i      (mem_rdata_i),
        .mem_ack_i        (mem_ack_i),
        .wb_valid_o       (wb_valid_o),
        .wb_data_o        (wb_data_o),
        .wb_data2_o       (wb_data2_o),
        .wb_dest_o        (wb_dest_o),
        .wb_dest2_o       (wb_dest2_o),
        .bus_err_o        (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one EX packet for a single clock, then drops valid.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] dest,
                         input logic [4:0] dest2);
        valid_i          = 1'b1;
        op_i             = op;
        memory_address_i = addr;
        store_data_i     = sdata;
        destination_i    = dest;
        destination2_i   = dest2;
        tick();
        valid_i = 1'b0;
        op_i    = NONE;
    endtask

    // Acks in the n-th ACCESS cycle; reports how many cycles stall was seen.
    task automatic ack_after(input int n, input logic [31:0] rdata, output int stalls);
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            if (stall_o) stalls++;
            if (i == n - 1) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdata;
            end
            tick();
        end
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
    endtask

    initial begin
        int stalls;
        int cyc;
        logic saw_wb;

        rst = 1'b1; valid_i = 1'b0; op_i = NONE; memory_address_i = '0;
        store_data_i = '0; result_i = '0; result2_i = '0; destination_i = '0;
        destination2_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
        tick(); tick();
        check("rst_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_stall", {31'b0, stall_o}, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
        check("rst_bus_err", {31'b0, bus_err_o}, 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        rst = 1'b0;
        tick();

        // Non-memory passthrough
        result_i = 32'h1234; result2_i = 32'h5678;
        issue(NONE, 32'h0, 32'h0, 5'd5, 5'd7);
        check("none_wb_valid", {31'b0, wb_valid_o}, 32'd1);
        check("none_wb_data", wb_data_o, 32'h1234);
        check("none_wb_data2", wb_data2_o, 32'h5678);
        check("none_wb_dest", {27'b0, wb_dest_o}, 32'd5);
        check("none_wb_dest2", {27'b0, wb_dest2_o}, 32'd7);
        check("none_req", {31'b0, mem_req_o}, 32'd0);
        tick();
        check("none_wb_pulse", {31'b0, wb_valid_o}, 32'd0);

        // LD_B with ack in the third ACCESS cycle
        issue(LD_B, 32'h103, 32'h0, 5'd3, 5'd9);
        check("ldb_req", {31'b0, mem_req_o}, 32'd1);
        check("ldb_we", {31'b0, mem_we_o}, 32'd0);
        check("ldb_addr", mem_addr_o, 32'h100);
        check("ldb_be", {28'b0, mem_be_o}, 32'h8);
        ack_after(3, 32'h80FF_0000, stalls);
        check("ldb_stall_cycles", stalls, 32'd3);
        check("ldb_wb_valid", {31'b0, wb_valid_o}, 32'd1);
        check("ldb_wb_data", wb_data_o, 32'hFFFF_FF80);
        check("ldb_wb_dest", {27'b0, wb_dest_o}, 32'd3);
        check("ldb_wb_dest2", {27'b0, wb_dest2_o}, 32'd0);
        check("ldb_wb_data2", wb_data2_o, 32'd0);
        check("ldb_req_drop", {31'b0, mem_req_o}, 32'd0);
        check("ldb_stall_drop", {31'b0, stall_o}, 32'd0);

        // LD_HU upper half, zero extended
        issue(LD_HU, 32'h202, 32'h0, 5'd4, 5'd0);
        check("ldhu_be", {28'b0, mem_be_o}, 32'hC);
        ack_after(1, 32'h8001_1234, stalls);
        check("ldhu_wb_data", wb_data_o, 32'h0000_8001);

        // LD_H lower half, sign extended
        issue(LD_H, 32'h200, 32'h0, 5'd6, 5'd0);
        check("ldh_be", {28'b0, mem_be_o}, 32'h3);
        ack_after(1, 32'h1234_F00F, stalls);
        check("ldh_wb_data", wb_data_o, 32'hFFFF_F00F);

        // ST_B lane replication and retire marker
        issue(ST_B, 32'h301, 32'hAB, 5'd8, 5'd2);
        check("stb_we", {31'b0, mem_we_o}, 32'd1);
        check("stb_be", {28'b0, mem_be_o}, 32'h2);
        check("stb_wdata", mem_wdata_o, 32'hABAB_ABAB);
        check("stb_addr", mem_addr_o, 32'h300);
        ack_after(2, 32'hFFFF_FFFF, stalls);
        check("stb_wb_valid", {31'b0, wb_valid_o}, 32'd1);
        check("stb_wb_dest", {27'b0, wb_dest_o}, 32'd0);
        check("stb_wb_dest2", {27'b0, wb_dest2_o}, 32'd0);

        // ST_H upper lane
        issue(ST_H, 32'h102, 32'h1234_ABCD, 5'd1, 5'd0);
        check("sth_be", {28'b0, mem_be_o}, 32'hC);
        check("sth_wdata", mem_wdata_o, 32'hABCD_ABCD);
        ack_after(1, 32'h0, stalls);

        // Ack while idle is ignored
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        tick();
        mem_ack_i = 1'b0;
        check("idle_ack_wb", {31'b0, wb_valid_o}, 32'd0);
        check("idle_ack_req", {31'b0, mem_req_o}, 32'd0);

        // Timeout: no ack for 16 ACCESS cycles
        issue(LD_W, 32'h400, 32'h0, 5'd10, 5'd0);
        cyc = 0; saw_wb = 1'b0;
        while (!bus_err_o && cyc < 40) begin
            tick();
            cyc++;
            if (wb_valid_o) saw_wb = 1'b1;
        end
        check("to_cycles", cyc, 32'd16);
        check("to_bus_err", {31'b0, bus_err_o}, 32'd1);
        check("to_req", {31'b0, mem_req_o}, 32'd0);
        check("to_stall", {31'b0, stall_o}, 32'd0);
        check("to_no_wb", {31'b0, saw_wb}, 32'd0);
        tick();
        check("to_err_pulse", {31'b0, bus_err_o}, 32'd0);
        result_i = 32'h77; result2_i = 32'h0;
        issue(NONE, 32'h0, 32'h0, 5'd2, 5'd0);
        check("to_next_op", wb_data_o, 32'h77);

        // Ack on the last timeout cycle wins
        issue(LD_BU, 32'h001, 32'h0, 5'd11, 5'd0);
        for (int i = 0; i < 15; i++) tick();
        check("to_edge_stall", {31'b0, stall_o}, 32'd1);
        ack_after(1, 32'h0000_A500, stalls);
        check("to_edge_wb_valid", {31'b0, wb_valid_o}, 32'd1);
        check("to_edge_no_err", {31'b0, bus_err_o}, 32'd0);
        check("to_edge_data", wb_data_o, 32'h0000_00A5);

        // Asynchronous reset mid-ACCESS
        issue(LD_W, 32'h500, 32'h0, 5'd12, 5'd0);
        tick();
        check("mid_req_before", {31'b0, mem_req_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", {31'b0, mem_req_o}, 32'd0);
        check("mid_rst_stall", {31'b0, stall_o}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_no_wb", {31'b0, wb_valid_o}, 32'd0);

        // Misaligned word load
        issue(LD_W, 32'h2, 32'h0, 5'd13, 5'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_no_req", {31'b0, mem_req_o}, 32'd0);
        check("mis_bus_err", {31'b0, bus_err_o}, 32'd1);
        check("mis_no_wb", {31'b0, wb_valid_o}, 32'd0);
        check("mis_stall", {31'b0, stall_o}, 32'd0);
`else
        check("mis_req", {31'b0, mem_req_o}, 32'd1);
        check("mis_be", {28'b0, mem_be_o}, 32'hF);
        check("mis_addr", mem_addr_o, 32'h0);
        ack_after(1, 32'hCAFE_F00D, stalls);
        check("mis_wb_data", wb_data_o, 32'hCAFE_F00D);
        check("mis_no_err", {31'b0, bus_err_o}, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
